// File: rtl/ntt_seq.sv
// Sequencer for the dual-pipelined NTT: feeds P coefficient pairs, collects P results, and drives the shared FIFO addresses.
// The read address leads the NTT input enable by one cycle. Writes follow ntt_out_en with no stall, and a drain watchdog aborts a stuck transform.
module ntt_seq #(
    parameter int STAGE_CNT      = 7,
    parameter int MUL_STAGE_CNT  = 4,
    parameter int MUL_STAGE_BITS = 2,
    parameter int FIFO2_BITS     = 5,
    parameter int TIMEOUT        = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic                            rd_en,
    output logic [STAGE_CNT-1:0]            rd_addr,
    output logic                            ntt_in_en,
    input  logic                            ntt_out_en,
    output logic                            wr_en,
    output logic [STAGE_CNT-1:0]            wr_addr,
    input  logic [STAGE_CNT-1:0]            fifo_en,
    output logic [MUL_STAGE_BITS-1:0]       fifom_addr,
    output logic [FIFO2_BITS*STAGE_CNT-1:0] fifo2_addr
);

    localparam int P       = 1 << STAGE_CNT;
    localparam int TO_BITS = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t                    state, state_n;
    logic [STAGE_CNT-1:0]      rd_cnt;
    logic [STAGE_CNT-1:0]      wr_cnt;
    logic [TO_BITS-1:0]        to_cnt;
    logic [MUL_STAGE_BITS-1:0] fm_cnt;
    logic                      last_wr;
    logic                      set_err;

    assign rd_addr    = rd_cnt;
    assign wr_addr    = wr_cnt;
    assign fifom_addr = fm_cnt;

    always_comb begin
        state_n = state;
        set_err = 1'b0;
        busy    = (state == S_FEED) || (state == S_DRAIN);
        done    = (state == S_DONE);
        rd_en   = (state == S_FEED);
        wr_en   = ntt_out_en && busy;
        last_wr = wr_en && (wr_cnt == STAGE_CNT'(P - 1));
        case (state)
            S_IDLE:  if (start) state_n = S_FEED;
            S_FEED:  if (rd_cnt == STAGE_CNT'(P - 1)) state_n = S_DRAIN;
            S_DRAIN: begin
                // Completion takes priority over a watchdog expiring in the same cycle.
                if (last_wr) begin
                    state_n = S_DONE;
                end else if (to_cnt == TO_BITS'(TIMEOUT - 1)) begin
                    state_n = S_IDLE;
                    set_err = 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            to_cnt    <= '0;
            fm_cnt    <= '0;
            ntt_in_en <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            ntt_in_en <= rd_en;
            rd_cnt    <= (state == S_FEED) ? rd_cnt + 1'b1 : '0;
            to_cnt    <= (state == S_DRAIN) ? to_cnt + 1'b1 : '0;
            if (state == S_IDLE)
                wr_cnt <= '0;
            else if (wr_en)
                wr_cnt <= wr_cnt + 1'b1;
            if ((state == S_IDLE) && start)
                err <= 1'b0;
            else if (set_err)
                err <= 1'b1;
            // Starts at 0 on the first FEED cycle and is back at 0 on every IDLE cycle.
            if ((state == S_IDLE) || (state_n == S_IDLE))
                fm_cnt <= '0;
            else if (fm_cnt == MUL_STAGE_BITS'(MUL_STAGE_CNT - 2))
                fm_cnt <= '0;
            else
                fm_cnt <= fm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < STAGE_CNT; i++) begin : g_f2
        localparam int H = 1 << (STAGE_CNT - 1 - i);
        localparam int F = (H > MUL_STAGE_CNT) ? (H - MUL_STAGE_CNT - 1) : (MUL_STAGE_CNT - H - 1);
        if ((i == 0) || (F <= 1)) begin : g_zero
            logic unused_fifo_en;
            assign unused_fifo_en = fifo_en[i];
            assign fifo2_addr[i*FIFO2_BITS +: FIFO2_BITS] = '0;
        end else begin : g_cnt
            // Circular buffer pointer: survives across transforms, only rst clears it.
            logic [FIFO2_BITS-1:0] cnt;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    cnt <= '0;
                else if (fifo_en[i])
                    cnt <= (cnt == FIFO2_BITS'(F - 1)) ? '0 : cnt + 1'b1;
            end
            assign fifo2_addr[i*FIFO2_BITS +: FIFO2_BITS] = cnt;
        end
    end

endmodule
